mul_cell_pipe: RTL and testbench



---
 rtl/mul_cell_pkg.sv | 17 +
 rtl/mul_cell_pipe_if.sv | 36 +++
 rtl/mul_cell_slice.sv | 20 ++
 rtl/mul_cell_pipe.sv | 121 ++++++++++++
 tb/tb_mul_cell_pipe.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mul_cell_pkg.sv
// Shared types and defaults for the sliced pipelined multiply cell.
package mul_cell_pkg;
  localparam int W_DEF = 32;
  localparam int S_DEF = 16;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } op_e;

  // Every op except MUL returns the upper half of the 2W-bit product.
  function automatic logic sel_high(input op_e op);
    return op != OP_MUL;
  endfunction
endpackage

// File: rtl/mul_cell_pipe_if.sv
// Operand/result handshake bundle for mul_cell_pipe; optional in_acc/in_acc_clr
// exist only when MUL_CELL_PIPE_ACC_EN is defined.
interface mul_cell_pipe_if
  import mul_cell_pkg::*;
#(
  parameter int W = W_DEF
) ();
  logic         in_valid;
  logic         in_ready;
  op_e          in_op;
  logic [W-1:0] in_src1;
  logic [W-1:0] in_src2;
`ifdef MUL_CELL_PIPE_ACC_EN
  logic         in_acc;
  logic         in_acc_clr;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;

  modport master (
`ifdef MUL_CELL_PIPE_ACC_EN
    output in_acc, in_acc_clr,
`endif
    output in_valid, in_op, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
`ifdef MUL_CELL_PIPE_ACC_EN
    input  in_acc, in_acc_clr,
`endif
    input  in_valid, in_op, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/mul_cell_slice.sv
// Registered SxS unsigned multiplier with load enable and async clear.
// One cycle latency; holds its product while en is low.
module mul_cell_slice #(
  parameter int S = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [S-1:0]   a,
  input  logic [S-1:0]   b,
  output logic [2*S-1:0] p
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
    end else if (en) begin
      p <= {{S{1'b0}}, a} * {{S{1'b0}}, b};
    end
  end
endmodule

// File: rtl/mul_cell_pipe.sv
// Two-stage WxW multiply cell (slice products, then sum + sign fix), elastic
// valid/ready, 2-cycle latency, 1/cycle; optional accumulator via MUL_CELL_PIPE_ACC_EN.
module mul_cell_pipe
  import mul_cell_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int S = S_DEF
) (
  input logic            clk,
  input logic            reset,
  mul_cell_pipe_if.slave bus
);
  localparam int N = W / S;

  logic accept, adv1, adv2;
  logic s1_valid, s2_valid;

  assign adv2         = ~s2_valid | bus.out_ready;
  assign adv1         = ~s1_valid | adv2;
  assign bus.in_ready = adv1 & ~reset;
  assign accept       = bus.in_valid & bus.in_ready;

  // ---------------- Stage 1: slice products and correction terms
  logic [2*S-1:0] prod [N*N];

  for (genvar gi = 0; gi < N; gi++) begin : g_a
    for (genvar gj = 0; gj < N; gj++) begin : g_b
      mul_cell_slice #(.S(S)) u_slice (
        .clk   (clk),
        .reset (reset),
        .en    (adv1),
        .a     (bus.in_src1[gi*S +: S]),
        .b     (bus.in_src2[gj*S +: S]),
        .p     (prod[gi*N+gj])
      );
    end
  end

  op_e          op_q;
  logic         neg_a_q, neg_b_q;
  logic [W-1:0] src1_q, src2_q;
`ifdef MUL_CELL_PIPE_ACC_EN
  logic         acc_q1, acc_clr_q1;
  logic [2*W-1:0] acc_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      op_q     <= OP_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
`ifdef MUL_CELL_PIPE_ACC_EN
      acc_q1     <= 1'b0;
      acc_clr_q1 <= 1'b0;
`endif
    end else if (adv1) begin
      s1_valid <= accept;
      op_q     <= bus.in_op;
      neg_a_q  <= bus.in_src1[W-1] & bus.in_op[1];
      neg_b_q  <= bus.in_src2[W-1] & (bus.in_op == OP_MULXSS);
      src1_q   <= bus.in_src1;
      src2_q   <= bus.in_src2;
`ifdef MUL_CELL_PIPE_ACC_EN
      acc_q1     <= bus.in_acc;
      acc_clr_q1 <= bus.in_acc_clr;
`endif
    end
  end

  // ---------------- Stage 2: unsigned sum, then subtract the two's-complement weights
  logic [2*W-1:0] sum;
  logic [2*W-1:0] full;
  logic [W-1:0]   res_nxt;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum = sum + ((2*W)'(prod[i*N+j]) << (S*(i+j)));
      end
    end
    if (neg_a_q) sum = sum - {src2_q, {W{1'b0}}};
    if (neg_b_q) sum = sum - {src1_q, {W{1'b0}}};
  end

`ifdef MUL_CELL_PIPE_ACC_EN
  logic [2*W-1:0] acc_nxt;
  assign acc_nxt = (acc_clr_q1 ? '0 : acc_q) + sum;
  assign full    = acc_q1 ? acc_nxt : sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (adv2 && s1_valid && acc_q1) begin
      acc_q <= acc_nxt;
    end
  end
`else
  assign full = sum;
`endif

  assign res_nxt = sel_high(op_q) ? full[2*W-1:W] : full[W-1:0];

  logic [W-1:0] result_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      result_q <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) result_q <= res_nxt;
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_result = result_q;
endmodule

// File: tb/tb_mul_cell_pipe.sv
// Directed self-checking bench for mul_cell_pipe (W=32, S=16).
module tb_mul_cell_pipe;
  import mul_cell_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mul_cell_pipe_if #(.W(32)) bus ();

  mul_cell_pipe #(.W(32), .S(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
  endtask

  // One isolated transaction with out_ready high; starts and ends just after a posedge.
  task automatic run_one(input string tag, input op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(bus.in_ready), 64'(1));
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_v1"}, 64'(bus.out_valid), 64'(0));
    cyc();
    @(negedge clk);
    check({tag, "_v2"}, 64'(bus.out_valid), 64'(1));
    check({tag, "_res"}, 64'(bus.out_result), 64'(exp));
    cyc();
  endtask

  initial begin
    op_e         bop [4];
    logic [31:0] ba  [4];
    logic [31:0] bb  [4];
    logic [31:0] bex [4];

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_MUL;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.out_ready = 1'b0;
`ifdef MUL_CELL_PIPE_ACC_EN
    bus.in_acc     = 1'b0;
    bus.in_acc_clr = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_result", 64'(bus.out_result), 64'(0));
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
    cyc();

    // Single transactions, covering each op and sign boundary
    run_one("uu_max", OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_one("ss_m1x2", OP_MULXSS, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    run_one("su_m1x2", OP_MULXSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    run_one("uu_m1x2", OP_MULXUU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    run_one("mul_m1x2", OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
    run_one("ss_m1xm1", OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_one("su_m1xmax", OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_one("ss_minxmin", OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_one("mul_sgn_lo", OP_MUL, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1);

    // Back-to-back: four accepts on consecutive cycles, no bubbles on output
    bop[0] = OP_MUL;    ba[0] = 32'd3;        bb[0] = 32'd5;        bex[0] = 32'd15;
    bop[1] = OP_MUL;    ba[1] = 32'd7;        bb[1] = 32'd9;        bex[1] = 32'd63;
    bop[2] = OP_MULXUU; ba[2] = 32'h0001_0000; bb[2] = 32'h0001_0000; bex[2] = 32'd1;
    bop[3] = OP_MUL;    ba[3] = 32'd2;        bb[3] = 32'd2;        bex[3] = 32'd4;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(bop[k], ba[k], bb[k]);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (k < 4) check($sformatf("b2b_rdy%0d", k), 64'(bus.in_ready), 64'(1));
      if (k >= 2 && k < 6) begin
        check($sformatf("b2b_v%0d", k - 2), 64'(bus.out_valid), 64'(1));
        check($sformatf("b2b_res%0d", k - 2), 64'(bus.out_result), 64'(bex[k-2]));
      end
      if (k == 6) check("b2b_idle", 64'(bus.out_valid), 64'(0));
      cyc();
    end

    // Backpressure: two items fill the pipe, the third is refused until release
    bus.out_ready = 1'b0;
    drive(OP_MUL, 32'd3, 32'd5);
    @(negedge clk);
    check("bp_rdy0", 64'(bus.in_ready), 64'(1));
    cyc();
    drive(OP_MUL, 32'd7, 32'd9);
    @(negedge clk);
    check("bp_rdy1", 64'(bus.in_ready), 64'(1));
    cyc();
    drive(OP_MUL, 32'd6, 32'd7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_full_rdy%0d", k), 64'(bus.in_ready), 64'(0));
      check($sformatf("bp_hold_v%0d", k), 64'(bus.out_valid), 64'(1));
      check($sformatf("bp_hold_res%0d", k), 64'(bus.out_result), 64'(15));
      cyc();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", 64'(bus.in_ready), 64'(1));
    check("bp_release_res", 64'(bus.out_result), 64'(15));
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_drain1_v", 64'(bus.out_valid), 64'(1));
    check("bp_drain1_res", 64'(bus.out_result), 64'(63));
    cyc();
    @(negedge clk);
    check("bp_drain2_v", 64'(bus.out_valid), 64'(1));
    check("bp_drain2_res", 64'(bus.out_result), 64'(42));
    cyc();
    @(negedge clk);
    check("bp_empty", 64'(bus.out_valid), 64'(0));
    cyc();

    // Reset while both stages are occupied
    bus.out_ready = 1'b0;
    drive(OP_MUL, 32'd11, 32'd13);
    cyc();
    drive(OP_MUL, 32'd17, 32'd19);
    cyc();
    @(negedge clk);
    check("mr_pre_v", 64'(bus.out_valid), 64'(1));
    cyc();
    reset = 1'b1;
    #1;
    check("mr_out_valid", 64'(bus.out_valid), 64'(0));
    check("mr_in_ready", 64'(bus.in_ready), 64'(0));
    cyc();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mr_no_stale%0d", k), 64'(bus.out_valid), 64'(0));
      cyc();
    end
    run_one("mr_6x7", OP_MUL, 32'd6, 32'd7, 32'd42);

`ifdef MUL_CELL_PIPE_ACC_EN
    // Accumulate: 3*4 with clear, 5*6 accumulated, 1*1 bypassing the accumulator
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin drive(OP_MUL, 32'd3, 32'd4); bus.in_acc = 1'b1; bus.in_acc_clr = 1'b1; end
        1: begin drive(OP_MUL, 32'd5, 32'd6); bus.in_acc = 1'b1; bus.in_acc_clr = 1'b0; end
        2: begin drive(OP_MUL, 32'd1, 32'd1); bus.in_acc = 1'b0; bus.in_acc_clr = 1'b0; end
        default: bus.in_valid = 1'b0;
      endcase
      @(negedge clk);
      if (k == 2) check("acc_res0", 64'(bus.out_result), 64'(12));
      if (k == 3) check("acc_res1", 64'(bus.out_result), 64'(42));
      if (k == 4) check("acc_res2", 64'(bus.out_result), 64'(1));
      cyc();
    end
    check("acc_hold", 64'(dut.acc_q), 64'(42));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
